hamming74_encoder_tx: RTL and testbench
=======================================

Name: hamming74_encoder_tx

Overview:
- Transmit-side counterpart of the Hamming(7,4) decoder project.
- Accepts 4-bit data nibbles over a valid/ready handshake and encodes each into a 7-bit Hamming codeword.
- Buffers codewords in a small FIFO and presents them on a valid/ready output that feeds the decoder's 7-bit io_in.
- Includes per-word single-bit error injection and a transmitted-word counter, so the decoder's correction path can be exercised end to end.

Parameters:
DEPTH, 4, FIFO depth in codewords; power of two, legal range 2..16.
CNT_W, 16, width of the transmitted-word counter.

Ports:
wb_clk_i  input  1  clock; all logic on rising edge
wb_rst_i  input  1  reset, synchronous, active-high
in_valid  input  1  in_data/inj_* are valid this cycle
in_ready  output 1  encoder can accept a nibble this cycle
in_data   input  4  data nibble d[3:0]
inj_en    input  1  flip one codeword bit for this word
inj_pos   input  3  Hamming position to flip (1..7); 0 = no flip
out_valid output 1  out_code holds a codeword
out_ready input  1  downstream consumes out_code this cycle
out_code  output 7  codeword; out_code[k] = Hamming position k+1
tx_count  output CNT_W  number of codewords popped since reset
level     output 5  current FIFO occupancy, 0..DEPTH

Behaviour:
- Encoding is combinational at the input and is stored in the FIFO as a 7-bit word.
- Data mapping: d1=d[0], d2=d[1], d3=d[2], d4=d[3].
- Parity: p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4.
- Codeword positions 1..7 = p1, p2, d1, p4, d2, d3, d4, mapped to out_code[0..6].
- Injection is sampled only on an accepted input. If inj_en=1 and inj_pos is in 1..7, bit inj_pos-1 of the encoded word is inverted before storage. If inj_pos=0 or inj_en=0, the word is stored unmodified.
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- in_ready = (level < DEPTH). It is a function of registered state only, never of out_ready, so there is no combinational in-to-out path.
- out_valid = (level != 0).
- out_code = FIFO head when out_valid=1, otherwise 7'b0.
- Latency: a word accepted in cycle N is visible on out_code with out_valid=1 in cycle N+1 at the earliest.
- Order is strictly FIFO; no reordering and no drops.
- Occupancy update:
  - Accept only: level+1.
  - Pop only: level-1.
  - Accept and pop in the same cycle (0 < level < DEPTH): level unchanged, both pointers advance.
- Full (level=DEPTH): in_ready=0; in_valid is ignored and no state changes on the input side. A pop in that cycle makes in_ready=1 in the next cycle.
- Empty (level=0): out_valid=0; out_ready is ignored, with no pop and no tx_count change. An accept into an empty FIFO is not passed through in the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately, so full and empty are unambiguous.
- tx_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Holding rule: while out_valid=1 and out_ready=0, out_code stays stable.
- Reset (wb_rst_i=1 at a rising edge, including mid-transfer):
  - Pointers, level and tx_count clear to 0.
  - In the following cycle out_valid=0, out_code=0, in_ready=1.
  - FIFO contents are discarded; storage itself need not be cleared.
  - While wb_rst_i=1, in_ready=0 and accepts are suppressed.
- Inputs carrying X while in_valid=0 must not affect state.

Test Plan:
- Golden encode: after reset, push d=4'b1101 with inj_en=0 → next cycle out_valid=1, out_code=7'b1100110; pop → tx_count=1, level=0.
- Exhaustive: push all 16 nibbles 0..15 with out_ready=1 throughout → outputs appear in order, each matching the parity equations (e.g. 0→7'b0000000, 15→7'b1111111, 1→7'b0000111); tx_count=16.
- Injection: push d=4'b1101 with inj_en=1, inj_pos=3 → out_code=7'b1100010. Repeat with inj_pos=0 → 7'b1100110.
- Full/backpressure: out_ready=0, push DEPTH+2 words → in_ready falls after the 4th accept, level=4, extra words are not stored. One pop, then push in the same cycle → level stays 4 and ordering is preserved.
- Simultaneous push/pop at level=2 for 10 cycles → level remains 2 and tx_count advances by 10. Pointer wrap is exercised.
- Mid-operation reset: level=3, assert wb_rst_i for one cycle → next cycle level=0, out_valid=0, out_code=0, tx_count=0. A subsequent push of 4'b1101 yields 7'b1100110.

Source files
------------

// File: rtl/hamming74_encoder_tx.sv
// Hamming(7,4) transmit encoder: nibbles in over valid/ready, codewords out of a small FIFO.
// Supports per-word single-bit error injection and counts every codeword popped.
module hamming74_encoder_tx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic             inj_en,
    input  logic [2:0]       inj_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_code,
    output logic [CNT_W-1:0] tx_count,
    output logic [4:0]       level
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    logic [6:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [6:0]       enc;
    logic [6:0]       flip;
    logic [6:0]       stored;
    logic             accept;
    logic             pop;

    // Codeword bit k holds Hamming position k+1: p1 p2 d1 p4 d2 d3 d4.
    always_comb begin
        enc[0] = in_data[0] ^ in_data[1] ^ in_data[3];
        enc[1] = in_data[0] ^ in_data[2] ^ in_data[3];
        enc[2] = in_data[0];
        enc[3] = in_data[1] ^ in_data[2] ^ in_data[3];
        enc[4] = in_data[1];
        enc[5] = in_data[2];
        enc[6] = in_data[3];
        // NOTE: default every always_comb output before the conditional write, otherwise a latch is inferred.
        flip = '0;
        if (inj_en && (inj_pos != 3'd0)) begin
            flip[inj_pos - 3'd1] = 1'b1;
        end
        stored = enc ^ flip;
    end

    // Ready depends only on registered state (and reset), never on out_ready.
    assign in_ready  = !wb_rst_i && (level < DEPTH_L);
    assign out_valid = (level != 5'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_code  = out_valid ? mem[rd_ptr] : 7'd0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            tx_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                tx_count <= tx_count + CNT_W'(1);
            end
            case ({accept, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; level and pointers alone define which entries are meaningful.
    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            mem[wr_ptr] <= stored;
        end
    end

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// Directed self-checking bench for hamming74_encoder_tx with hand-computed codewords.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled before the next edge.
module tb_hamming74_encoder_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        inj_en;
    logic [2:0]  inj_pos;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_code;
    logic [15:0] tx_count;
    logic [4:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-derived codewords for nibbles 0..15, written as out_code[6:0].
    logic [6:0] exp_tab [16] = '{
        7'b0000000, 7'b0000111, 7'b0011001, 7'b0011110,
        7'b0101010, 7'b0101101, 7'b0110011, 7'b0110100,
        7'b1001011, 7'b1001100, 7'b1010010, 7'b1010101,
        7'b1100001, 7'b1100110, 7'b1111000, 7'b1111111
    };

    hamming74_encoder_tx #(.DEPTH(4), .CNT_W(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .tx_count  (tx_count),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = 4'bxxxx;
        inj_en    = 1'bx;
        inj_pos   = 3'bxxx;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [3:0] d, input logic ie, input logic [2:0] ip);
        in_valid = 1'b1;
        in_data  = d;
        inj_en   = ie;
        inj_pos  = ip;
        step();
        idle_inputs();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_during: got %b expected 0", in_ready); end
        n_checks++;
        step();
        rst = 1'b0;
        #1;
        if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_code !== 7'd0) begin n_fail++; $display("FAIL reset_out_code: got %b expected 0000000", out_code); end
        n_checks++;
        if (tx_count !== 16'd0) begin n_fail++; $display("FAIL reset_tx_count: got %0d expected 0", tx_count); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
        n_checks++;
    endtask

    task automatic test_golden();
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'b1101;
        inj_en   = 1'b0;
        inj_pos  = 3'd0;
        #1;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL golden_no_passthrough: got %b expected 0", out_valid); end
        n_checks++;
        step();
        idle_inputs();
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL golden_out_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (out_code !== 7'b1100110) begin n_fail++; $display("FAIL golden_code: got %b expected 1100110", out_code); end
        n_checks++;
        if (level !== 5'd1) begin n_fail++; $display("FAIL golden_level1: got %0d expected 1", level); end
        n_checks++;
        pop_one();
        if (tx_count !== 16'd1) begin n_fail++; $display("FAIL golden_tx_count: got %0d expected 1", tx_count); end
        n_checks++;
        if (level !== 5'd0) begin n_fail++; $display("FAIL golden_level0: got %0d expected 0", level); end
        n_checks++;
        if (out_code !== 7'd0) begin n_fail++; $display("FAIL golden_empty_code: got %b expected 0000000", out_code); end
        n_checks++;
        // A pop request on an empty FIFO must not advance the counter.
        pop_one();
        if (tx_count !== 16'd1) begin n_fail++; $display("FAIL golden_empty_pop: got %0d expected 1", tx_count); end
        n_checks++;
    endtask

    task automatic test_exhaustive();
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            out_ready = 1'b1;
            if (i < 16) begin
                in_valid = 1'b1;
                in_data  = 4'(i);
                inj_en   = 1'b0;
                inj_pos  = 3'd0;
            end else begin
                in_valid = 1'b0;
                in_data  = 4'bxxxx;
            end
            #1;
            if (i > 0) begin
                if (out_valid !== 1'b1 || out_code !== exp_tab[i-1]) begin
                    n_fail++;
                    $display("FAIL exhaustive_code[%0d]: got valid=%b code=%b expected valid=1 code=%b", i-1, out_valid, out_code, exp_tab[i-1]);
                end
                n_checks++;
            end
            step();
        end
        idle_inputs();
        if (tx_count !== 16'd16) begin n_fail++; $display("FAIL exhaustive_tx_count: got %0d expected 16", tx_count); end
        n_checks++;
        if (level !== 5'd0) begin n_fail++; $display("FAIL exhaustive_level: got %0d expected 0", level); end
        n_checks++;
    endtask

    task automatic test_inject();
        do_reset();
        push(4'b1101, 1'b1, 3'd3);
        if (out_code !== 7'b1100010) begin n_fail++; $display("FAIL inject_pos3: got %b expected 1100010", out_code); end
        n_checks++;
        pop_one();
        push(4'b1101, 1'b1, 3'd0);
        if (out_code !== 7'b1100110) begin n_fail++; $display("FAIL inject_pos0: got %b expected 1100110", out_code); end
        n_checks++;
        pop_one();
        push(4'b1101, 1'b0, 3'd3);
        if (out_code !== 7'b1100110) begin n_fail++; $display("FAIL inject_disabled: got %b expected 1100110", out_code); end
        n_checks++;
        pop_one();
        push(4'b1101, 1'b1, 3'd7);
        if (out_code !== 7'b0100110) begin n_fail++; $display("FAIL inject_pos7: got %b expected 0100110", out_code); end
        n_checks++;
        pop_one();
        push(4'b0000, 1'b1, 3'd1);
        if (out_code !== 7'b0000001) begin n_fail++; $display("FAIL inject_pos1: got %b expected 0000001", out_code); end
        n_checks++;
        pop_one();
    endtask

    task automatic test_full();
        logic [3:0] drain_exp [4] = '{4'd1, 4'd2, 4'd3, 4'd9};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            inj_en   = 1'b0;
            inj_pos  = 3'd0;
            #1;
            if (in_ready !== (i < 4)) begin n_fail++; $display("FAIL full_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 4)); end
            n_checks++;
            step();
        end
        idle_inputs();
        if (level !== 5'd4) begin n_fail++; $display("FAIL full_level: got %0d expected 4", level); end
        n_checks++;
        if (out_code !== exp_tab[0]) begin n_fail++; $display("FAIL full_hold_code: got %b expected %b", out_code, exp_tab[0]); end
        n_checks++;
        // Pop while full with a word offered: the offered word must be ignored.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'd9;
        inj_en    = 1'b0;
        inj_pos   = 3'd0;
        step();
        out_ready = 1'b0;
        if (level !== 5'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: got level=%0d ready=%b expected level=3 ready=1", level, in_ready); end
        n_checks++;
        step();
        idle_inputs();
        if (level !== 5'd4) begin n_fail++; $display("FAIL full_refill_level: got %0d expected 4", level); end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            if (out_code !== exp_tab[drain_exp[i]]) begin n_fail++; $display("FAIL full_drain[%0d]: got %b expected %b", i, out_code, exp_tab[drain_exp[i]]); end
            n_checks++;
            pop_one();
        end
        if (tx_count !== 16'd5 || level !== 5'd0) begin n_fail++; $display("FAIL full_end: got tx=%0d level=%0d expected tx=5 level=0", tx_count, level); end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(4'd0, 1'b0, 3'd0);
        push(4'd1, 1'b0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_data   = 4'(i + 2);
            inj_en    = 1'b0;
            inj_pos   = 3'd0;
            out_ready = 1'b1;
            #1;
            if (out_code !== exp_tab[i]) begin n_fail++; $display("FAIL b2b_head[%0d]: got %b expected %b", i, out_code, exp_tab[i]); end
            n_checks++;
            step();
            if (level !== 5'd2) begin n_fail++; $display("FAIL b2b_level[%0d]: got %0d expected 2", i, level); end
            n_checks++;
        end
        idle_inputs();
        if (tx_count !== 16'd10) begin n_fail++; $display("FAIL b2b_tx_count: got %0d expected 10", tx_count); end
        n_checks++;
        for (int i = 10; i < 12; i++) begin
            if (out_code !== exp_tab[i]) begin n_fail++; $display("FAIL b2b_drain[%0d]: got %b expected %b", i, out_code, exp_tab[i]); end
            n_checks++;
            pop_one();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push(4'd3, 1'b0, 3'd0);
        push(4'd5, 1'b0, 3'd0);
        push(4'd7, 1'b0, 3'd0);
        pop_one();
        push(4'd8, 1'b0, 3'd0);
        if (level !== 5'd3 || tx_count !== 16'd1) begin n_fail++; $display("FAIL midrst_pre: got level=%0d tx=%0d expected level=3 tx=1", level, tx_count); end
        n_checks++;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'd5;
        inj_en    = 1'b0;
        inj_pos   = 3'd0;
        out_ready = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        if (level !== 5'd0 || out_valid !== 1'b0 || out_code !== 7'd0 || tx_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_state: got level=%0d valid=%b code=%b tx=%0d expected 0 0 0000000 0", level, out_valid, out_code, tx_count);
        end
        n_checks++;
        push(4'b1101, 1'b0, 3'd0);
        if (out_code !== 7'b1100110 || level !== 5'd1) begin n_fail++; $display("FAIL midrst_push: got code=%b level=%0d expected 1100110 1", out_code, level); end
        n_checks++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_golden();
        test_exhaustive();
        test_inject();
        test_full();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
